pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage pipeline.
- Generates the stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers. Its flush_E output drives the ID/EX register clr input.
- Generates the EX-stage and ID-stage forwarding selects.
- Freezes the whole pipeline while the data memory inserts wait states. A watchdog timeout, a sticky error flag and a saturating stall-cycle performance counter are included.

---
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and memory-wait sequencing for the 5-stage pipeline.
// Stall, flush and forwarding outputs are combinational from the inputs and the FSM state; mem_timeout and stall_cnt are registered.
// A data memory wait freezes every pipe register; a load-use or branch hazard stalls the front end; the ERR state freezes the pipe until reset.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [4:0]       rs_E,
    input  logic [4:0]       rt_E,
    input  logic [4:0]       writereg_E,
    input  logic [4:0]       writereg_M,
    input  logic [4:0]       writereg_W,
    input  logic             RegWrite_E,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic             MemtoReg_E,
    input  logic             MemtoReg_M,
    input  logic             branch_D,
    input  logic             pcsrc_D,
    input  logic             jump_D,
    input  logic             memacc_M,
    input  logic             dmem_ready,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic [1:0]       fwdA_E,
    output logic [1:0]       fwdB_E,
    output logic             fwdA_D,
    output logic             fwdB_D,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    // Wide enough to hold MAX_WAIT-1 plus headroom.
    localparam int WCW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic           lw_stall;
    logic           br_stall;
    logic           hz;
    logic           freeze;
    logic           mem_wait;

    // Register 0 is hardwired, so a destination of 0 never creates a dependency.
    function automatic logic dep(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    // Operand forwarding selects; MEM result has priority over WB. Forced to 0 in reset.
    always_comb begin
        fwdA_E = 2'b00;
        fwdB_E = 2'b00;
        fwdA_D = 1'b0;
        fwdB_D = 1'b0;
        if (rst_n) begin
            if (RegWrite_M && dep(writereg_M, rs_E))      fwdA_E = 2'b10;
            else if (RegWrite_W && dep(writereg_W, rs_E)) fwdA_E = 2'b01;
            if (RegWrite_M && dep(writereg_M, rt_E))      fwdB_E = 2'b10;
            else if (RegWrite_W && dep(writereg_W, rt_E)) fwdB_E = 2'b01;
            fwdA_D = RegWrite_M && dep(writereg_M, rs_D);
            fwdB_D = RegWrite_M && dep(writereg_M, rt_D);
        end
    end

    // Hazard detection: load-use into ID, and branch operands not yet available in ID.
    always_comb begin
        lw_stall = MemtoReg_E && (dep(rt_E, rs_D) || dep(rt_E, rt_D));
        br_stall = branch_D &&
                   ((RegWrite_E && (dep(writereg_E, rs_D) || dep(writereg_E, rt_D))) ||
                    (MemtoReg_M && (dep(writereg_M, rs_D) || dep(writereg_M, rt_D))));
        hz       = lw_stall || br_stall;
        mem_wait = memacc_M && !dmem_ready;
        freeze   = (state == ERR) || mem_wait;
    end

    // Stall/flush priority: freeze over hazard over branch/jump redirect.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_W = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                flush_W = 1'b1;
            end else if (hz) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end else begin
                flush_D = pcsrc_D || jump_D;
            end
        end
    end

    // Memory-wait watchdog: counts consecutive not-ready cycles, ERR is terminal until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_wait) begin
                        state    <= WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                WAIT: begin
                    if (dmem_ready || !memacc_M) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
                        state       <= ERR;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                ERR: begin
                    mem_timeout <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating count of front-end stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_F && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by randomized traffic.
// Expected values come from a cycle-level reference model of the pipeline control rules.
// Inputs change on the falling edge; outputs are compared just after, before the next rising edge.
module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 3;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs_D, rt_D, rs_E, rt_E, writereg_E, writereg_M, writereg_W;
    logic RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M;
    logic branch_D, pcsrc_D, jump_D, memacc_M, dmem_ready;
    logic stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
    logic [1:0] fwdA_E, fwdB_E;
    logic fwdA_D, fwdB_D, mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
        .writereg_E(writereg_E), .writereg_M(writereg_M), .writereg_W(writereg_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M),
        .branch_D(branch_D), .pcsrc_D(pcsrc_D), .jump_D(jump_D),
        .memacc_M(memacc_M), .dmem_ready(dmem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .fwdA_D(fwdA_D), .fwdB_D(fwdB_D),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: consecutive not-ready cycles, terminal error, stall cycle total.
    int m_nr;
    bit m_err;
    int m_cnt;

    // Expected outputs for the current cycle.
    bit e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fW, e_faD, e_fbD;
    int e_faE, e_fbE;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic bit uses(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 0) && (dst == src);
    endfunction

    task automatic predict();
        bit lw, br, frz;
        e_sF = 0; e_sD = 0; e_sE = 0; e_sM = 0; e_fD = 0; e_fE = 0; e_fW = 0;
        e_faE = 0; e_fbE = 0; e_faD = 0; e_fbD = 0;
        if (rst_n) begin
            e_faE = (RegWrite_M && uses(writereg_M, rs_E)) ? 2 : (RegWrite_W && uses(writereg_W, rs_E)) ? 1 : 0;
            e_fbE = (RegWrite_M && uses(writereg_M, rt_E)) ? 2 : (RegWrite_W && uses(writereg_W, rt_E)) ? 1 : 0;
            e_faD = RegWrite_M && uses(writereg_M, rs_D);
            e_fbD = RegWrite_M && uses(writereg_M, rt_D);
            lw  = MemtoReg_E && (uses(rt_E, rs_D) || uses(rt_E, rt_D));
            br  = branch_D && ((RegWrite_E && (uses(writereg_E, rs_D) || uses(writereg_E, rt_D))) ||
                               (MemtoReg_M && (uses(writereg_M, rs_D) || uses(writereg_M, rt_D))));
            frz = m_err || (memacc_M && !dmem_ready);
            if (frz) begin
                e_sF = 1; e_sD = 1; e_sE = 1; e_sM = 1; e_fW = 1;
            end else if (lw || br) begin
                e_sF = 1; e_sD = 1; e_fE = 1;
            end else begin
                e_fD = pcsrc_D || jump_D;
            end
        end
    endtask

    task automatic compare_all();
        check("stall_F", stall_F, e_sF);
        check("stall_D", stall_D, e_sD);
        check("stall_E", stall_E, e_sE);
        check("stall_M", stall_M, e_sM);
        check("flush_D", flush_D, e_fD);
        check("flush_E", flush_E, e_fE);
        check("flush_W", flush_W, e_fW);
        check("fwdA_E", fwdA_E, e_faE);
        check("fwdB_E", fwdB_E, e_fbE);
        check("fwdA_D", fwdA_D, e_faD);
        check("fwdB_D", fwdB_D, e_fbD);
        check("mem_timeout", mem_timeout, m_err);
        check("stall_cnt", stall_cnt, m_cnt);
    endtask

    // One clock cycle: compare against the model, then advance the model at the rising edge.
    task automatic step();
        #1;
        if (!rst_n) begin m_nr = 0; m_err = 0; m_cnt = 0; end
        predict();
        compare_all();
        @(posedge clk);
        if (rst_n) begin
            if (e_sF && m_cnt < CMAX) m_cnt++;
            if (!m_err) begin
                if (memacc_M && !dmem_ready) begin
                    m_nr++;
                    if (m_nr == MAX_WAIT) m_err = 1;
                end else begin
                    m_nr = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0;
        writereg_E = 0; writereg_M = 0; writereg_W = 0;
        RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
        MemtoReg_E = 0; MemtoReg_M = 0;
        branch_D = 0; pcsrc_D = 0; jump_D = 0;
        memacc_M = 0; dmem_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        m_nr = 0; m_err = 0; m_cnt = 0;
        @(negedge clk);
        do_reset();

        // Forwarding priority: MEM over WB, register 0 never forwards.
        rs_E = 5; RegWrite_M = 1; writereg_M = 5; RegWrite_W = 1; writereg_W = 5;
        #1 check("fwd_mem_prio", fwdA_E, 2);
        step();
        RegWrite_M = 0;
        #1 check("fwd_wb", fwdA_E, 1);
        step();
        rs_E = 0; writereg_W = 0;
        #1 check("fwd_r0", fwdA_E, 0);
        step();

        // Load-use stall suppresses the taken-branch redirect.
        do_reset();
        MemtoReg_E = 1; rt_E = 8; rs_D = 8; pcsrc_D = 1;
        #1 check("lw_stall_F", stall_F, 1);
        check("lw_flush_E", flush_E, 1);
        check("lw_no_flush_D", flush_D, 0);
        step();
        step();
        #1 check("lw_cnt_2", stall_cnt, 2);
        step();

        // Branch operand hazard, then redirect once the dependency is gone.
        do_reset();
        branch_D = 1; rt_D = 3; RegWrite_E = 1; writereg_E = 3;
        #1 check("br_stall", stall_F, 1);
        step();
        writereg_E = 4; pcsrc_D = 1;
        #1 check("br_redirect", flush_D, 1);
        step();

        // Memory wait of 3 cycles freezes the pipe exactly that long, no timeout.
        do_reset();
        memacc_M = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check("wait_stall_M", stall_M, 1);
            check("wait_flush_W", flush_W, 1);
            step();
        end
        dmem_ready = 1;
        #1 check("wait_release", stall_M, 0);
        check("wait_no_timeout", mem_timeout, 0);
        step();

        // Timeout after MAX_WAIT consecutive not-ready cycles; freeze is sticky.
        do_reset();
        memacc_M = 1; dmem_ready = 0;
        for (int i = 0; i < MAX_WAIT - 1; i++) step();
        #1 check("timeout_not_yet", mem_timeout, 0);
        step();
        #1 check("timeout_set", mem_timeout, 1);
        dmem_ready = 1;
        #1 check("err_freeze", stall_F, 1);
        step();
        memacc_M = 0;
        step();

        // Stall counter saturation.
        do_reset();
        MemtoReg_E = 1; rt_E = 8; rs_D = 8;
        for (int i = 0; i < 10; i++) step();
        #1 check("cnt_sat", stall_cnt, CMAX);
        step();

        // Asynchronous reset in the middle of a wait.
        do_reset();
        memacc_M = 1; dmem_ready = 0; rs_E = 5; RegWrite_M = 1; writereg_M = 5;
        step();
        step();
        @(posedge clk);
        #2 rst_n = 0;
        #1 check("arst_stall_F", stall_F, 0);
        check("arst_flush_W", flush_W, 0);
        check("arst_fwdA_E", fwdA_E, 0);
        check("arst_cnt", stall_cnt, 0);
        check("arst_timeout", mem_timeout, 0);
        @(negedge clk);
        step();
        rst_n = 1;
        idle_inputs();
        step();

        // Randomized traffic with occasional resets and varying memory readiness.
        begin
            int ready_pct;
            ready_pct = 70;
            for (int i = 0; i < 3000; i++) begin
                if (i % 100 == 0) ready_pct = $urandom_range(10, 90);
                rst_n      = ($urandom_range(0, 149) != 0);
                rs_D       = 5'($urandom_range(0, 3));
                rt_D       = 5'($urandom_range(0, 3));
                rs_E       = 5'($urandom_range(0, 3));
                rt_E       = 5'($urandom_range(0, 3));
                writereg_E = 5'($urandom_range(0, 3));
                writereg_M = 5'($urandom_range(0, 3));
                writereg_W = 5'($urandom_range(0, 3));
                RegWrite_E = 1'($urandom_range(0, 1));
                RegWrite_M = 1'($urandom_range(0, 1));
                RegWrite_W = 1'($urandom_range(0, 1));
                MemtoReg_E = 1'($urandom_range(0, 1));
                MemtoReg_M = 1'($urandom_range(0, 1));
                branch_D   = 1'($urandom_range(0, 1));
                pcsrc_D    = 1'($urandom_range(0, 1));
                jump_D     = ($urandom_range(0, 3) == 0);
                memacc_M   = ($urandom_range(0, 3) != 0);
                dmem_ready = ($urandom_range(0, 99) < ready_pct);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
